// File: rtl/alarm_chime_ctrl.sv
// Alarm/chime buzzer controller: rings at the programmed hh:mm:00 with stop,
// snooze and auto-off, and sounds an hourly chime of N beeps on a 12 h dial.
module alarm_chime_ctrl #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3,
  parameter int unsigned CHIME_TMO   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_on,
  input  logic       chime_on,
  input  logic       key_stop,
  input  logic       key_snooze,
  input  logic       beep_gate,
  output logic       buzz_en,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_left
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    CHIME  = 2'd3
  } state_t;

  localparam logic [7:0] LP_RING_LAST = 8'(RING_SECS - 1);
  localparam logic [9:0] LP_SNZ_LAST  = 10'(SNOOZE_SECS - 1);
  localparam logic [7:0] LP_TMO_LAST  = 8'(CHIME_TMO - 1);
  localparam logic [1:0] LP_MAX_SNZ   = 2'(MAX_SNOOZE);

  state_t     r_state;
  state_t     w_nxt;
  logic [7:0] r_ring_cnt;
  logic [9:0] r_snz_cnt;
  logic [7:0] r_tmo_cnt;
  logic [3:0] r_beep_cnt;
  logic [3:0] r_chime_n;
  logic       r_gate_q;
  logic       r_buzz_en;
  logic       r_ringing;
  logic       r_snoozing;
  logic [1:0] r_snooze_left;

  logic       w_alarm_hit;
  logic       w_chime_hit;
  logic       w_fall;
  logic [3:0] w_hmod;
  logic [3:0] w_chime_n;

  assign w_alarm_hit = tick_1hz & alarm_on & (cur_hour == alarm_hour) &
                       (cur_min == alarm_min) & (cur_sec == 6'd0);
  assign w_chime_hit = tick_1hz & chime_on & (cur_min == 6'd0) &
                       (cur_sec == 6'd0) & ~w_alarm_hit;
  assign w_fall      = r_gate_q & ~beep_gate;
  assign w_hmod      = (cur_hour >= 5'd12) ? 4'(cur_hour - 5'd12) : cur_hour[3:0];
  assign w_chime_n   = (w_hmod == 4'd0) ? 4'd12 : w_hmod;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_alarm_hit)      w_nxt = RING;
        else if (w_chime_hit) w_nxt = CHIME;
      end
      RING: begin
        if (key_stop || !alarm_on)                        w_nxt = IDLE;
        else if (key_snooze && r_snooze_left != 2'd0)     w_nxt = SNOOZE;
        else if (tick_1hz && r_ring_cnt >= LP_RING_LAST)  w_nxt = IDLE;
      end
      SNOOZE: begin
        if (key_stop || !alarm_on)                        w_nxt = IDLE;
        else if (tick_1hz && r_snz_cnt >= LP_SNZ_LAST)    w_nxt = RING;
      end
      CHIME: begin
        if (w_alarm_hit)                                  w_nxt = RING;
        else if (w_fall && r_beep_cnt >= r_chime_n - 4'd1) w_nxt = IDLE;
        else if (tick_1hz && r_tmo_cnt >= LP_TMO_LAST)    w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_ring_cnt    <= '0;
      r_snz_cnt     <= '0;
      r_tmo_cnt     <= '0;
      r_beep_cnt    <= '0;
      r_chime_n     <= '0;
      r_gate_q      <= 1'b0;
      r_buzz_en     <= 1'b0;
      r_ringing     <= 1'b0;
      r_snoozing    <= 1'b0;
      r_snooze_left <= LP_MAX_SNZ;
    end else begin
      r_state    <= w_nxt;
      r_buzz_en  <= (w_nxt == RING) || (w_nxt == CHIME);
      r_ringing  <= (w_nxt == RING);
      r_snoozing <= (w_nxt == SNOOZE);
      // Clearing the sample on CHIME entry means only a gate seen high inside CHIME can count as a fall.
      r_gate_q   <= (w_nxt == CHIME && r_state != CHIME) ? 1'b0 : beep_gate;
      case (w_nxt)
        IDLE: r_snooze_left <= LP_MAX_SNZ;
        RING: begin
          if (r_state != RING)                        r_ring_cnt <= '0;
          else if (tick_1hz && r_ring_cnt != '1)      r_ring_cnt <= r_ring_cnt + 8'd1;
        end
        SNOOZE: begin
          if (r_state != SNOOZE) begin
            r_snz_cnt     <= '0;
            r_snooze_left <= r_snooze_left - 2'd1;
          end else if (tick_1hz && r_snz_cnt != '1) begin
            r_snz_cnt <= r_snz_cnt + 10'd1;
          end
        end
        CHIME: begin
          if (r_state != CHIME) begin
            r_beep_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_chime_n  <= w_chime_n;
          end else begin
            if (w_fall && r_beep_cnt != '1)  r_beep_cnt <= r_beep_cnt + 4'd1;
            if (tick_1hz && r_tmo_cnt != '1) r_tmo_cnt  <= r_tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign buzz_en     = r_buzz_en;
  assign ringing     = r_ringing;
  assign snoozing    = r_snoozing;
  assign snooze_left = r_snooze_left;

endmodule

// File: tb/tb_alarm_chime_ctrl.sv
// Directed bench for alarm_chime_ctrl with small timing parameters.
module tb_alarm_chime_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_on;
  logic       chime_on;
  logic       key_stop;
  logic       key_snooze;
  logic       beep_gate;
  logic       buzz_en;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_left;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  alarm_chime_ctrl #(
    .RING_SECS  (4),
    .SNOOZE_SECS(3),
    .MAX_SNOOZE (2),
    .CHIME_TMO  (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_on   (alarm_on),
    .chime_on   (chime_on),
    .key_stop   (key_stop),
    .key_snooze (key_snooze),
    .beep_gate  (beep_gate),
    .buzz_en    (buzz_en),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_left(snooze_left)
  );

  // Expected value packs {buzz_en, ringing, snoozing, snooze_left}.
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {buzz_en, ringing, snoozing, snooze_left};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    cur_hour = h; cur_min = m; cur_sec = s; tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
  endtask

  task automatic keys(input logic stop, input logic snz);
    key_stop = stop; key_snooze = snz;
    @(negedge clk);
    key_stop = 1'b0; key_snooze = 1'b0;
  endtask

  task automatic beep();
    beep_gate = 1'b1;
    @(negedge clk);
    @(negedge clk);
    beep_gate = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [4:0] S_IDLE2 = 5'b000_10;
  localparam logic [4:0] S_RING2 = 5'b110_10;
  localparam logic [4:0] S_CHM2  = 5'b100_10;

  initial begin
    rst = 1'b0; tick_1hz = 1'b0; cur_hour = '0; cur_min = '0; cur_sec = '0;
    alarm_hour = 5'd7; alarm_min = 6'd30; alarm_on = 1'b1; chime_on = 1'b0;
    key_stop = 1'b0; key_snooze = 1'b0; beep_gate = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", S_IDLE2);
    rst = 1'b1;
    @(negedge clk);

    // T1: ring and auto-off after 4 ticks
    tick(5'd7, 6'd29, 6'd59);
    chk("no_hit_early", S_IDLE2);
    tick(5'd7, 6'd30, 6'd0);
    chk("t1_ring", S_RING2);
    for (int i = 1; i <= 3; i++) tick(5'd7, 6'd30, 6'(i));
    chk("t1_ring_3ticks", S_RING2);
    tick(5'd7, 6'd30, 6'd4);
    chk("t1_autooff", S_IDLE2);

    keys(1'b1, 1'b1);
    chk("keys_in_idle", S_IDLE2);

    // T2: snooze and re-ring
    tick(5'd7, 6'd30, 6'd0);
    chk("t2_ring", S_RING2);
    keys(1'b0, 1'b1);
    chk("t2_snooze", 5'b001_01);
    tick(5'd7, 6'd30, 6'd1);
    tick(5'd7, 6'd30, 6'd2);
    chk("t2_snooze_2ticks", 5'b001_01);
    tick(5'd7, 6'd30, 6'd3);
    chk("t2_rering", 5'b110_01);

    // T3: snooze limit, re-trigger ignored, stop restores count
    keys(1'b0, 1'b1);
    chk("t3_snooze2", 5'b001_00);
    for (int i = 4; i <= 6; i++) tick(5'd7, 6'd30, 6'(i));
    chk("t3_rering2", 5'b110_00);
    keys(1'b0, 1'b1);
    chk("t3_snooze_ignored", 5'b110_00);
    tick(5'd7, 6'd30, 6'd0);
    chk("t3_hit_in_ring", 5'b110_00);
    keys(1'b1, 1'b0);
    chk("t3_stop", S_IDLE2);

    // alarm_on dropped while ringing
    tick(5'd7, 6'd30, 6'd0);
    chk("disarm_ring", S_RING2);
    alarm_on = 1'b0;
    @(negedge clk);
    chk("disarm_idle", S_IDLE2);
    alarm_on = 1'b1;

    // T4: 15:00 chime, three beeps
    chime_on = 1'b1;
    tick(5'd15, 6'd0, 6'd0);
    chk("t4_chime", S_CHM2);
    beep();
    beep();
    chk("t4_two_beeps", S_CHM2);
    beep();
    chk("t4_done", S_IDLE2);

    // T5: midnight chime, twelve beeps
    tick(5'd0, 6'd0, 6'd0);
    chk("t5_chime12", S_CHM2);
    for (int i = 0; i < 11; i++) beep();
    chk("t5_eleven_beeps", S_CHM2);
    beep();
    chk("t5_twelve_done", S_IDLE2);

    // T5: watchdog with the gate stuck low
    tick(5'd12, 6'd0, 6'd0);
    chk("t5_wd_enter", S_CHM2);
    for (int i = 1; i <= 14; i++) tick(5'd12, 6'd0, 6'(i));
    chk("t5_wd_14", S_CHM2);
    tick(5'd12, 6'd0, 6'd15);
    chk("t5_wd_exit", S_IDLE2);

    // alarm takes precedence over a coincident or running chime
    alarm_hour = 5'd8; alarm_min = 6'd0;
    tick(5'd8, 6'd0, 6'd0);
    chk("alarm_over_chime", S_RING2);
    keys(1'b1, 1'b0);
    alarm_hour = 5'd9; alarm_min = 6'd1;
    tick(5'd9, 6'd0, 6'd0);
    chk("chime_9", S_CHM2);
    keys(1'b1, 1'b1);
    chk("keys_in_chime", S_CHM2);
    tick(5'd9, 6'd1, 6'd0);
    chk("alarm_preempt", S_RING2);

    // T6: stop and snooze together, then async reset
    keys(1'b1, 1'b1);
    chk("t6_stop_wins", S_IDLE2);
    tick(5'd9, 6'd1, 6'd0);
    chk("t6_ring", S_RING2);
    #2 rst = 1'b0;
    #1 chk("t6_async_rst", S_IDLE2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_after_rst", S_IDLE2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
